mul_arbiter: RTL
================

Name: mul_arbiter

Overview:
- Shares one multi-cycle fast multiplier between two requesters.
- Each requester presents a pair of operands and raises a request. The arbiter grants one requester, drives the multiplier's start/operand interface and waits for done.
- It then returns the 2*WIDTH product to the winner with a one-cycle acknowledge.
- Sits between the display/top-level logic and the multiplier core, replacing direct wiring of a single controller.

Parameters:
- WIDTH, 16, operand width in bits; product width is 2*WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request, level.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- ack0  out  1  requester 0 completion pulse; result valid this cycle.
- req1  in  1  requester 1 request, level.
- a1  in  WIDTH  requester 1 operand A.
- b1  in  WIDTH  requester 1 operand B.
- ack1  out  1  requester 1 completion pulse.
- result  out  2*WIDTH  product of the last completed operation, held until the next completion.
- grant  out  1  id of the requester currently or last served.
- busy  out  1  high whenever state is not IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH  registered operand A to the multiplier.
- mul_b  out  WIDTH  registered operand B to the multiplier.
- mul_done  in  1  multiplier completion pulse.
- mul_product  in  2*WIDTH  multiplier result, valid when mul_done=1.

Behaviour:
- Reset values: state=IDLE; ack0=ack1=0; mul_start=0; mul_a=mul_b=0; result=0; grant=0; busy=0; round-robin pointer favours requester 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester.
- IDLE, both requests: grant the requester not served last. After reset this is requester 0.
- On grant: latch that requester's a/b into mul_a/mul_b, set grant, go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle; go to WAIT.
- WAIT: hold mul_a/mul_b stable. On mul_done=1, capture mul_product into result and go to RESP.
- mul_done is sampled only in WAIT. A done pulse in IDLE, ISSUE or RESP is ignored.
- RESP: ack of the granted requester=1 for one cycle; the other ack stays 0. Update the round-robin pointer to the served id, then return to IDLE.
- Latency: req sampled high in IDLE at edge N → mul_start high in cycle N+1. mul_done seen in cycle M → ack and new result visible in cycle M+1.
- Minimum overhead is 3 cycles plus multiplier latency.
- Operands are sampled only at grant. Changing a/b or dropping req after grant does not abort the operation; ack is still pulsed and result still updates.
- Back-to-back: a requester holding req through ack is treated as a new request in the following IDLE cycle and re-arbitrated.
  - If both requesters are active, service alternates strictly 0,1,0,1…
- Arithmetic: result is exactly mul_product. The arbiter does no truncation and no sign handling.
- Reset mid-operation (any state): return immediately to reset values. The in-flight operation is dropped and no ack is issued. The multiplier shares the same reset.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: MUL_ARB_FIXED_PRIO_EN.
- Defined: round-robin pointer removed; requester 0 always wins simultaneous requests. Requester 1 is served only when req0=0 in the IDLE decision cycle.
- Undefined: round-robin arbitration as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Single op, requester 0: reset, then req0=1, a0=16'h0003, b0=16'h0005, multiplier done 4 cycles after start. Expect: mul_start one cycle after req; mul_a=3, mul_b=5; ack0 one cycle after mul_done; result=32'h0000000F; ack1 never set.
- Simultaneous requests: req0 and req1 held high with distinct operands. Expect: grants alternate 0,1,0,1 across four operations, and each result matches its requester's a*b. With MUL_ARB_FIXED_PRIO_EN defined, all four grants go to 0.
- Max operands: a1=b1=16'hFFFF. Expect result=32'hFFFE0001, ack1 pulse, grant=1.
- Operand change after grant: change a0 to 16'h0009 during WAIT. Expect mul_a unchanged and result computed from the original operands.
- Spurious done: mul_done pulses while in IDLE and during ISSUE. Expect no state change, no ack and result unchanged; the real done in WAIT completes normally.
- Reset in WAIT: assert reset for one cycle mid-operation, then send a late mul_done. Expect all outputs back to 0, busy=0, no ack; a subsequent req1 is served normally.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Bus bundle between two operand requesters, the mul_arbiter and a multi-cycle multiplier core.
// slave is the arbiter's view; master is the view of everything around it.
interface mul_arbiter_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               ack0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               ack1;
  logic [2*WIDTH-1:0] result;
  logic               grant;
  logic               busy;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_done, mul_product,
    output ack0, ack1, result, grant, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req0, a0, b0, req1, a1, b1, mul_done, mul_product,
    input  ack0, ack1, result, grant, busy, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between two requesters (round-robin on simultaneous requests).
// Define MUL_ARB_FIXED_PRIO_EN to make requester 0 always win instead.
module mul_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input logic          clock,
  input logic          reset,
  mul_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               grant_q, grant_d;
  logic               pick1;

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign pick1 = !bus.req0;
`else
  // Id that wins the next simultaneous request: the one not served last.
  logic prio_q, prio_d;
  assign pick1 = bus.req1 && (!bus.req0 || prio_q);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      grant_q  <= 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      grant_q  <= grant_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
      prio_q   <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    grant_d  = grant_q;
`ifndef MUL_ARB_FIXED_PRIO_EN
    prio_d   = prio_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          grant_d = pick1;
          mul_a_d = pick1 ? bus.a1 : bus.a0;
          mul_b_d = pick1 ? bus.b1 : bus.b0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.mul_done) begin
          result_d = bus.mul_product;
          state_d  = StResp;
        end
      end
      StResp: begin
`ifndef MUL_ARB_FIXED_PRIO_EN
        prio_d  = !grant_q;
`endif
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.mul_start = (state_q == StIssue);
  assign bus.ack0      = (state_q == StResp) && !grant_q;
  assign bus.ack1      = (state_q == StResp) && grant_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.result    = result_q;
  assign bus.grant     = grant_q;

endmodule
